peripheral_wb_spram_master: RTL and testbench

PERIPHERAL_WB_SPRAM_MASTER -- requirements
Module: peripheral_wb_spram_master

---
 rtl/peripheral_wb_spram_master.sv | 151 +++++++++++++++
 tb/tb_peripheral_wb_spram_master.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_wb_spram_master.sv
// Wishbone burst master for a single-port RAM: turns a command plus a write-data
// stream into classic/incrementing WB cycles, and returns read beats as pulses.
module peripheral_wb_spram_master #(
    parameter int DEPTH = 256,
    parameter int DW    = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [7:0]      cmd_len,
    input  logic            wdat_valid,
    output logic            wdat_ready,
    input  logic [DW-1:0]   wdat,
    output logic            rdat_valid,
    output logic [DW-1:0]   rdat,
    output logic            done,
    output logic            err,
    output logic [AW-1:0]   wb_adr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    output logic            wb_we_o,
    output logic [1:0]      wb_bte_o,
    output logic [2:0]      wb_cti_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,
    input  logic [DW-1:0]   wb_dat_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_BUS
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          we_q, we_d;
    logic [7:0]    rem_q, rem_d;
    logic          single_q, single_d;
    logic [DW-1:0] rdat_q, rdat_d;
    logic          rdat_valid_q, rdat_valid_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [AW-1:0] adr_inc;

    // Address wraps at DEPTH, which need not be a power of two.
    assign adr_inc = (adr_q == AW'(DEPTH - 1)) ? '0 : adr_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        we_d         = we_q;
        rem_d        = rem_q;
        single_d     = single_q;
        rdat_d       = rdat_q;
        rdat_valid_d = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    adr_d    = cmd_adr;
                    we_d     = cmd_we;
                    rem_d    = cmd_len;
                    single_d = (cmd_len == 8'd0);
                    state_d  = cmd_we ? S_FETCH : S_BUS;
                end
            end
            S_FETCH: begin
                if (wdat_valid) begin
                    dat_d   = wdat;
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                if (wb_err_i) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else if (wb_ack_i) begin
                    if (!we_q) begin
                        rdat_d       = wb_dat_i;
                        rdat_valid_d = 1'b1;
                    end
                    if (rem_q != 8'd0) begin
                        adr_d   = adr_inc;
                        rem_d   = rem_q - 8'd1;
                        state_d = we_q ? S_FETCH : S_BUS;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q      <= S_IDLE;
            adr_q        <= '0;
            dat_q        <= '0;
            we_q         <= 1'b0;
            rem_q        <= '0;
            single_q     <= 1'b0;
            rdat_q       <= '0;
            rdat_valid_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            we_q         <= we_d;
            rem_q        <= rem_d;
            single_q     <= single_d;
            rdat_q       <= rdat_d;
            rdat_valid_q <= rdat_valid_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign wdat_ready = (state_q == S_FETCH);
    assign wb_cyc_o   = (state_q != S_IDLE);
    assign wb_stb_o   = (state_q == S_BUS);
    assign wb_sel_o   = wb_stb_o ? '1 : '0;
    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = dat_q;
    assign wb_we_o    = we_q;
    assign wb_bte_o   = 2'b00;
    // Single-beat commands are classic cycles; bursts end with the end-of-burst code.
    assign wb_cti_o   = !wb_stb_o ? 3'b000 :
                        single_q  ? 3'b000 :
                        (rem_q != 8'd0) ? 3'b010 : 3'b111;
    assign rdat_valid = rdat_valid_q;
    assign rdat       = rdat_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_peripheral_wb_spram_master.sv
// Bench for peripheral_wb_spram_master: WB slave, write-data feeder and monitor run
// on the falling edge; each command is checked against expectations built from the rules.
module tb_peripheral_wb_spram_master;

    localparam int DEPTH = 256;
    localparam int DW    = 32;
    localparam int AW    = 8;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [AW-1:0] cmd_adr = '0;
    logic [7:0]    cmd_len = '0;
    logic          wdat_valid;
    logic          wdat_ready;
    logic [DW-1:0] wdat;
    logic          rdat_valid;
    logic [DW-1:0] rdat;
    logic          done;
    logic          err;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [3:0]    wb_sel_o;
    logic          wb_we_o;
    logic [1:0]    wb_bte_o;
    logic [2:0]    wb_cti_o;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic          wb_ack_i;
    logic          wb_err_i;
    logic [DW-1:0] wb_dat_i;

    always #5 wb_clk_i = ~wb_clk_i;

    peripheral_wb_spram_master #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_len(cmd_len),
        .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat),
        .rdat_valid(rdat_valid), .rdat(rdat), .done(done), .err(err),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_bte_o(wb_bte_o), .wb_cti_o(wb_cti_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_dat_i(wb_dat_i)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Command configuration, written only by the main sequence.
    int            epoch = 0;
    int            cfg_wait = 0, cfg_err_at = 999, cfg_hold_beat = 999, cfg_hold = 0, cfg_n = 0;
    logic [31:0]   cfg_seed = '0;
    logic [DW-1:0] wdata [256];
    logic          cur_we;
    int            cur_adr, cur_len;

    // Slave log of every responded beat.
    logic [AW-1:0] lg_adr[$];
    logic [DW-1:0] lg_dat[$];
    logic [3:0]    lg_sel[$];
    logic [2:0]    lg_cti[$];
    logic [1:0]    lg_bte[$];
    logic          lg_we[$];

    // Monitor results.
    logic [DW-1:0] m_rd[$];
    int            m_done, m_cyc_n, m_fetch_n;
    logic          m_err, m_cyc_at_done, m_rdy_at_done;

    function automatic logic [DW-1:0] rd_of(input logic [31:0] seed, input logic [AW-1:0] a);
        return seed ^ ({24'b0, a} * 32'h9E37_79B1);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // WB slave: cfg_wait wait states per beat; beat index cfg_err_at answers with err.
    initial begin
        int s_epoch = 0, s_cnt = 0, s_idx = 0;
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = '0;
        forever begin
            @(negedge wb_clk_i);
            if (s_epoch != epoch) begin
                s_epoch = epoch; s_cnt = 0; s_idx = 0;
                lg_adr.delete(); lg_dat.delete(); lg_sel.delete();
                lg_cti.delete(); lg_bte.delete(); lg_we.delete();
            end
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            if (wb_cyc_o && wb_stb_o) begin
                if (s_cnt >= cfg_wait) begin
                    s_cnt = 0;
                    if (s_idx == cfg_err_at) wb_err_i = 1'b1;
                    else                     wb_ack_i = 1'b1;
                    wb_dat_i = rd_of(cfg_seed, wb_adr_o);
                    lg_adr.push_back(wb_adr_o); lg_dat.push_back(wb_dat_o);
                    lg_sel.push_back(wb_sel_o); lg_cti.push_back(wb_cti_o);
                    lg_bte.push_back(wb_bte_o); lg_we.push_back(wb_we_o);
                    s_idx++;
                end else begin
                    s_cnt++;
                end
            end else begin
                s_cnt = 0;
            end
        end
    end

    // Write-data source; withholds cfg_hold FETCH cycles before beat cfg_hold_beat.
    initial begin
        int  f_epoch = 0, f_idx = 0, f_hold = 0;
        logic f_took = 1'b0;
        wdat_valid = 1'b0; wdat = '0;
        forever begin
            @(negedge wb_clk_i);
            if (f_epoch != epoch) begin
                f_epoch = epoch; f_idx = 0; f_hold = cfg_hold; f_took = 1'b0;
            end
            if (f_took) f_idx++;
            if (f_idx == cfg_hold_beat && f_hold > 0) begin
                wdat_valid = 1'b0;
                if (wdat_ready) f_hold--;
            end else if (f_idx < cfg_n) begin
                wdat_valid = 1'b1;
                wdat = wdata[f_idx];
            end else begin
                wdat_valid = 1'b0;
            end
            f_took = wdat_valid && wdat_ready;
        end
    end

    initial begin
        int m_epoch = 0;
        m_done = 0; m_cyc_n = 0; m_fetch_n = 0;
        m_err = 1'b0; m_cyc_at_done = 1'b0; m_rdy_at_done = 1'b0;
        forever begin
            @(negedge wb_clk_i);
            if (m_epoch != epoch) begin
                m_epoch = epoch; m_rd.delete();
                m_done = 0; m_cyc_n = 0; m_fetch_n = 0;
                m_err = 1'b0; m_cyc_at_done = 1'b0; m_rdy_at_done = 1'b0;
            end
            if (rdat_valid) m_rd.push_back(rdat);
            if (done) begin
                m_done++; m_err = err;
                m_cyc_at_done = wb_cyc_o; m_rdy_at_done = cmd_ready;
            end
            if (wb_cyc_o) m_cyc_n++;
            if (wb_cyc_o && !wb_stb_o) m_fetch_n++;
        end
    end

    task automatic start_cmd(input string tag, input logic we, input int adr, input int len,
                             input int wt, input int errat, input int hb, input int hc);
        @(negedge wb_clk_i);
        cur_we = we; cur_adr = adr; cur_len = len;
        cfg_wait = wt; cfg_err_at = errat; cfg_hold_beat = hb; cfg_hold = hc;
        cfg_n = len + 1; cfg_seed = $urandom;
        for (int i = 0; i <= len; i++) wdata[i] = $urandom;
        epoch++;
        repeat (2) @(negedge wb_clk_i);
        check({tag, " ready_idle"}, 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = AW'(adr); cmd_len = 8'(len);
        @(negedge wb_clk_i);
        cmd_valid = 1'b0; cmd_adr = AW'($urandom); cmd_len = 8'($urandom);
        check({tag, " ready_busy"}, 64'(cmd_ready), 64'(0));
    endtask

    task automatic finish_cmd(input string tag);
        int beats, nb, acked, fetch_exp;
        for (int c = 0; c < 3000 && m_done == 0; c++) @(negedge wb_clk_i);
        repeat (4) @(negedge wb_clk_i);
        beats = cur_len + 1;
        nb    = (cfg_err_at < beats) ? cfg_err_at + 1 : beats;
        acked = (cfg_err_at < beats) ? cfg_err_at : beats;
        fetch_exp = cur_we ? nb + ((cfg_hold_beat < nb) ? cfg_hold : 0) : 0;
        check({tag, " done_cnt"}, 64'(m_done), 64'(1));
        check({tag, " err"}, 64'(m_err), 64'(cfg_err_at < beats));
        check({tag, " cyc_at_done"}, 64'(m_cyc_at_done), 64'(0));
        check({tag, " rdy_at_done"}, 64'(m_rdy_at_done), 64'(1));
        check({tag, " beats"}, 64'(lg_adr.size()), 64'(nb));
        for (int i = 0; i < nb && i < lg_adr.size(); i++) begin
            check($sformatf("%s adr[%0d]", tag, i), 64'(lg_adr[i]), 64'((cur_adr + i) % DEPTH));
            check($sformatf("%s cti[%0d]", tag, i), 64'(lg_cti[i]),
                  64'((cur_len == 0) ? 0 : (i == cur_len) ? 7 : 2));
            check($sformatf("%s sel[%0d]", tag, i), 64'(lg_sel[i]), 64'(4'hF));
            check($sformatf("%s bte[%0d]", tag, i), 64'(lg_bte[i]), 64'(0));
            check($sformatf("%s we[%0d]", tag, i), 64'(lg_we[i]), 64'(cur_we));
            if (cur_we) check($sformatf("%s wdat[%0d]", tag, i), 64'(lg_dat[i]), 64'(wdata[i]));
        end
        check({tag, " rd_cnt"}, 64'(m_rd.size()), 64'(cur_we ? 0 : acked));
        for (int i = 0; i < m_rd.size() && i < acked; i++)
            check($sformatf("%s rdat[%0d]", tag, i), 64'(m_rd[i]),
                  64'(rd_of(cfg_seed, AW'((cur_adr + i) % DEPTH))));
        check({tag, " fetch_cyc"}, 64'(m_fetch_n), 64'(fetch_exp));
        check({tag, " cyc_cyc"}, 64'(m_cyc_n), 64'(nb * (cfg_wait + 1) + fetch_exp));
    endtask

    task automatic run_cmd(input string tag, input logic we, input int adr, input int len,
                           input int wt, input int errat, input int hb, input int hc);
        start_cmd(tag, we, adr, len, wt, errat, hb, hc);
        finish_cmd(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        // Reset state
        repeat (3) @(negedge wb_clk_i);
        check("rst cmd_ready", 64'(cmd_ready), 64'(1));
        check("rst wdat_ready", 64'(wdat_ready), 64'(0));
        check("rst cyc", 64'(wb_cyc_o), 64'(0));
        check("rst stb", 64'(wb_stb_o), 64'(0));
        check("rst we", 64'(wb_we_o), 64'(0));
        check("rst adr", 64'(wb_adr_o), 64'(0));
        check("rst dat", 64'(wb_dat_o), 64'(0));
        check("rst sel", 64'(wb_sel_o), 64'(0));
        check("rst cti", 64'(wb_cti_o), 64'(0));
        check("rst rdat", 64'(rdat), 64'(0));
        check("rst rdat_valid", 64'(rdat_valid), 64'(0));
        check("rst done_err", 64'({done, err}), 64'(0));
        wb_rst_i = 1'b1;
        repeat (2) @(negedge wb_clk_i);

        run_cmd("rd1",      1'b0, 'h10, 0, 2, 999, 999, 0);
        run_cmd("rd4",      1'b0, 'h20, 3, 0, 999, 999, 0);
        run_cmd("wr3_hold", 1'b1, 'h00, 2, 0, 999, 1, 3);
        run_cmd("rd_wrap",  1'b0, 'hFE, 3, 0, 999, 999, 0);
        run_cmd("rd_err",   1'b0, 'h40, 3, 0, 1, 999, 0);
        run_cmd("wr1_err",  1'b1, 'h33, 0, 1, 0, 999, 0);
        run_cmd("wr1",      1'b1, 'h7F, 0, 0, 999, 999, 0);

        // Reset during beat 3 of an 8-beat write
        start_cmd("wr_rst", 1'b1, 'h50, 7, 3, 999, 999, 0);
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge wb_clk_i);
            ok = (lg_adr.size() == 2) && wb_stb_o;
        end
        check("wr_rst reach_beat3", 64'(ok), 64'(1));
        #2 wb_rst_i = 1'b0;
        #1;
        check("wr_rst cyc", 64'(wb_cyc_o), 64'(0));
        check("wr_rst stb", 64'(wb_stb_o), 64'(0));
        check("wr_rst cmd_ready", 64'(cmd_ready), 64'(1));
        repeat (3) @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        repeat (4) @(negedge wb_clk_i);
        check("wr_rst no_done", 64'(m_done), 64'(0));
        run_cmd("after_rst", 1'b0, 'h60, 2, 1, 999, 999, 0);

        for (int k = 0; k < 10; k++) begin
            int len, errat;
            len   = $urandom_range(0, 9);
            errat = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : 999;
            run_cmd($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1),
                    len, $urandom_range(0, 2), errat, $urandom_range(0, 9), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
